// File: rtl/char_window_scheduler_pkg.sv
// Shared types for the character window scheduler.
// FSM states, box layout and box validity helper.
package char_rec_pkg;

  localparam int BOX_W  = 12;
  localparam int CHAR_W = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_SOF,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [BOX_W-1:0] hl;
    logic [BOX_W-1:0] hr;
    logic [BOX_W-1:0] vl;
    logic [BOX_W-1:0] vr;
  } box_t;

  function automatic logic box_valid(box_t b);
    return (b.hl < b.hr) && (b.vl < b.vr);
  endfunction

endpackage

// File: rtl/char_window_scheduler_if.sv
// Control, config and result bus of the scheduler.
// master = controller side, slave = scheduler.
interface char_window_scheduler_if #(
  parameter int MAX_CHARS = 8
);
  localparam int IDXW = $clog2(MAX_CHARS);

  logic            start;
  logic            abort;
  logic [IDXW:0]   num_chars;
  logic            cfg_we;
  logic [IDXW-1:0] cfg_idx;
  logic [47:0]     cfg_box;
  logic            i_vsync;
  logic [39:0]     char_in;
  logic [2:0]      frame_cnt;
  logic [11:0]     hcount_l;
  logic [11:0]     hcount_r;
  logic [11:0]     vcount_l;
  logic [11:0]     vcount_r;
  logic            res_we;
  logic [IDXW-1:0] res_idx;
  logic [39:0]     res_char;
  logic            busy;
  logic            done;
  logic            cfg_err;

  modport master (
    output start, abort, num_chars,
    output cfg_we, cfg_idx, cfg_box,
    output i_vsync, char_in,
    input  frame_cnt,
    input  hcount_l, hcount_r,
    input  vcount_l, vcount_r,
    input  res_we, res_idx, res_char,
    input  busy, done, cfg_err
  );

  modport slave (
    input  start, abort, num_chars,
    input  cfg_we, cfg_idx, cfg_box,
    input  i_vsync, char_in,
    output frame_cnt,
    output hcount_l, hcount_r,
    output vcount_l, vcount_r,
    output res_we, res_idx, res_char,
    output busy, done, cfg_err
  );

endinterface

// File: rtl/char_window_scheduler_vsync_edge_det.sv
// Registered vsync edge detector.
// fe_o pulses one cycle after vsync enters its active level.
module vsync_edge_det #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic fe_o
);

  logic act_d;
  logic act_q;
  logic fe_q;

  assign act_d = (vsync_i == VS_POL);
  assign fe_o  = fe_q;

  // delay the active level and flag its rising transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      act_q <= act_d;
      fe_q  <= act_d & ~act_q;
    end
  end

endmodule

// File: rtl/char_window_scheduler.sv
// Walks the box table, one box per FRAMES_PER_CHAR frames,
// and writes each recognised character to the result port.
module char_window_scheduler
  import char_rec_pkg::*;
#(
  parameter int MAX_CHARS       = 8,
  parameter int FRAMES_PER_CHAR = 2,
  parameter bit VS_POL          = 1'b1
) (
  input logic pixel_clk,
  input logic reset_n,
  char_window_scheduler_if.slave bus
);

  localparam int IDXW = $clog2(MAX_CHARS);
  localparam logic [IDXW:0] MAXN =
    (IDXW+1)'(MAX_CHARS);
  localparam logic [2:0] LASTF =
    3'(FRAMES_PER_CHAR - 1);

  box_t            tbl_q [MAX_CHARS];
  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW:0]   n_q;
  logic            skip_q;
  logic [2:0]      fc_q;
  box_t            crd_q;
  logic            res_we_q;
  logic [IDXW-1:0] res_idx_q;
  logic [39:0]     res_char_q;
  logic            busy_q;
  logic            done_q;
  logic            cfg_err_q;

  logic            fe;
  logic [IDXW:0]   n_d;
  box_t            box_d;
  logic            last_d;
  logic            cfg_bad_d;

  vsync_edge_det #(
    .VS_POL (VS_POL)
  ) u_fe (
    .clk     (pixel_clk),
    .rst_n   (reset_n),
    .vsync_i (bus.i_vsync),
    .fe_o    (fe)
  );

  // clamp request, pick current box, spot last box and bad cfg
  always_comb begin
    n_d = (bus.num_chars > MAXN) ? MAXN : bus.num_chars;
    box_d = tbl_q[idx_q];
    last_d = (({1'b0, idx_q} + (IDXW+1)'(1)) == n_q);
    cfg_bad_d = (state_q != S_IDLE) ||
      ({1'b0, bus.cfg_idx} >= MAXN);
  end

  // box table writes, refused while a run is active
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_CHARS; i++)
        tbl_q[i] <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we & cfg_bad_d;
      if (bus.cfg_we && !cfg_bad_d)
        tbl_q[bus.cfg_idx] <= bus.cfg_box;
    end
  end

  // scheduling FSM with registered outputs
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      skip_q     <= 1'b0;
      fc_q       <= '0;
      crd_q      <= '0;
      res_we_q   <= 1'b0;
      res_idx_q  <= '0;
      res_char_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      res_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (bus.abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        fc_q    <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              idx_q   <= '0;
              n_q     <= n_d;
              busy_q  <= 1'b1;
              state_q <= (n_d == '0) ? S_DONE : S_LOAD;
            end
          end
          S_LOAD: begin
            crd_q <= box_d;
            fc_q  <= '0;
            if (box_valid(box_d)) begin
              skip_q  <= 1'b0;
              state_q <= S_WAIT_SOF;
            end else begin
              skip_q  <= 1'b1;
              state_q <= S_STORE;
            end
          end
          S_WAIT_SOF: begin
            if (fe)
              state_q <= S_RUN;
          end
          S_RUN: begin
            if (fe) begin
              if (fc_q == LASTF)
                state_q <= S_STORE;
              else
                fc_q <= fc_q + 3'd1;
            end
          end
          S_STORE: begin
            res_we_q   <= 1'b1;
            res_idx_q  <= idx_q;
            res_char_q <= skip_q ? '0 : bus.char_in;
            idx_q      <= idx_q + 1'b1;
            state_q    <= last_d ? S_DONE : S_LOAD;
          end
          S_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.frame_cnt = fc_q;
  assign bus.hcount_l  = crd_q.hl;
  assign bus.hcount_r  = crd_q.hr;
  assign bus.vcount_l  = crd_q.vl;
  assign bus.vcount_r  = crd_q.vr;
  assign bus.res_we    = res_we_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_char  = res_char_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_char_window_scheduler.sv
// Directed bench for char_window_scheduler.
// Frame-numbered char_in makes each captured value predictable.
module tb_char_window_scheduler;

  localparam logic [39:0] BASE = 40'hA500000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  char_window_scheduler_if #(.MAX_CHARS(8)) bus ();

  char_window_scheduler #(
    .MAX_CHARS       (8),
    .FRAMES_PER_CHAR (2),
    .VS_POL          (1'b1)
  ) dut (
    .pixel_clk (clk),
    .reset_n   (rst_n),
    .bus       (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;
  int fnum = 0;

  int nres = 0;
  int ndone = 0;
  int nfc = 0;
  int ncrd = 0;
  logic [2:0]  r_idx [64];
  logic [39:0] r_chr [64];
  logic [47:0] r_box [64];
  logic [2:0]  fc_log [64];
  logic [2:0]  prev_fc = '0;
  logic [47:0] prev_box = '0;
  logic [47:0] cur_box;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [47:0] vbox(int k);
    return {12'(10 + k), 12'(100 + k),
            12'(20 + k), 12'(200 + k)};
  endfunction

  // observe outputs away from the active edge
  always @(negedge clk) begin
    cur_box = {bus.hcount_l, bus.hcount_r,
               bus.vcount_l, bus.vcount_r};
    if (bus.res_we) begin
      if (nres < 64) begin
        r_idx[nres] = bus.res_idx;
        r_chr[nres] = bus.res_char;
        r_box[nres] = cur_box;
      end
      nres++;
    end
    if (bus.done) ndone++;
    if (bus.frame_cnt !== prev_fc) begin
      if (nfc < 64) fc_log[nfc] = bus.frame_cnt;
      nfc++;
    end
    prev_fc = bus.frame_cnt;
    if (cur_box !== prev_box) ncrd++;
    prev_box = cur_box;
  end

  task automatic cfg_write(input int idx,
                           input logic [47:0] b);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1;
    bus.cfg_idx = 3'(idx);
    bus.cfg_box = b;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    bus.num_chars = 4'(n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      fnum++;
      bus.char_in = BASE + 40'(fnum);
      bus.i_vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.i_vsync = 1'b0;
      repeat (17) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_res(input string t, input int k,
                         input logic [2:0] idx,
                         input logic [39:0] chr);
    chk($sformatf("%s idx%0d", t, k), 64'(r_idx[k]), 64'(idx));
    chk($sformatf("%s chr%0d", t, k), 64'(r_chr[k]), 64'(chr));
  endtask

  int r0, d0, f0, c0;
  logic [2:0] fseq [5];

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_chars = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_box = '0;
    bus.i_vsync = 1'b0;
    bus.char_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst busy", 64'(bus.busy), 0);
    chk("rst done", 64'(bus.done), 0);
    chk("rst res_we", 64'(bus.res_we), 0);
    chk("rst fcnt", 64'(bus.frame_cnt), 0);
    chk("rst hl", 64'(bus.hcount_l), 0);
    chk("rst cfg_err", 64'(bus.cfg_err), 0);

    // three valid boxes
    for (int k = 0; k < 3; k++) cfg_write(k, vbox(k));
    r0 = nres; d0 = ndone; f0 = nfc; c0 = ncrd;
    fnum = 0;
    pulse_start(3);
    chk("t1 busy", 64'(bus.busy), 1);
    run_frames(10);
    chk("t1 nres", 64'(nres - r0), 3);
    for (int k = 0; k < 3; k++) begin
      chk_res("t1", r0 + k, 3'(k), BASE + 40'(3 * (k + 1)));
      chk($sformatf("t1 box%0d", k), 64'(r_box[r0 + k]),
          64'(vbox(k)));
    end
    chk("t1 done", 64'(ndone - d0), 1);
    chk("t1 idle", 64'(bus.busy), 0);
    fseq = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    chk("t2 nfc", 64'(nfc - f0), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2 fc%0d", i), 64'(fc_log[f0 + i]),
          64'(fseq[i]));
    chk("t2 crd chg", 64'(ncrd - c0), 3);

    // invalid box 1 is skipped
    cfg_write(1, {12'd100, 12'd50, 12'd10, 12'd20});
    r0 = nres; d0 = ndone; fnum = 0;
    pulse_start(3);
    run_frames(7);
    chk("t3 nres", 64'(nres - r0), 3);
    chk_res("t3", r0, 3'd0, BASE + 40'd3);
    chk_res("t3", r0 + 1, 3'd1, 40'h0);
    chk_res("t3", r0 + 2, 3'd2, BASE + 40'd6);
    chk("t3 done", 64'(ndone - d0), 1);

    // zero boxes: done two cycles after start
    r0 = nres; d0 = ndone;
    @(posedge clk); #1;
    bus.num_chars = '0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("t4 done early", 64'(bus.done), 0);
    chk("t4 busy", 64'(bus.busy), 1);
    @(negedge clk);
    chk("t4 done", 64'(bus.done), 1);
    chk("t4 busy off", 64'(bus.busy), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4 nres", 64'(nres - r0), 0);
    chk("t4 ndone", 64'(ndone - d0), 1);

    // clamp 15 to 8
    cfg_write(1, vbox(1));
    for (int k = 3; k < 8; k++) cfg_write(k, vbox(k));
    r0 = nres; d0 = ndone; fnum = 0;
    pulse_start(15);
    run_frames(25);
    chk("t4 clamp nres", 64'(nres - r0), 8);
    for (int k = 0; k < 8; k++)
      chk_res("t4c", r0 + k, 3'(k), BASE + 40'(3 * (k + 1)));
    chk("t4 clamp done", 64'(ndone - d0), 1);

    // cfg write and start during a run
    r0 = nres; d0 = ndone; fnum = 0;
    pulse_start(2);
    fork
      run_frames(7);
      begin
        repeat (25) @(posedge clk);
        #1;
        bus.cfg_we = 1'b1;
        bus.cfg_idx = 3'd1;
        bus.cfg_box = 48'h001002003004;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        @(negedge clk);
        chk("t5 cfg_err", 64'(bus.cfg_err), 1);
        @(negedge clk);
        chk("t5 cfg_err off", 64'(bus.cfg_err), 0);
        @(posedge clk); #1;
        bus.num_chars = 4'd1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    join
    chk("t5 nres", 64'(nres - r0), 2);
    chk_res("t5", r0, 3'd0, BASE + 40'd3);
    chk_res("t5", r0 + 1, 3'd1, BASE + 40'd6);
    chk("t5 box1", 64'(r_box[r0 + 1]), 64'(vbox(1)));
    chk("t5 done", 64'(ndone - d0), 1);

    // start with abort in the same cycle
    @(posedge clk); #1;
    bus.num_chars = 4'd3;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t6 start+abort", 64'(bus.busy), 0);

    // abort in RUN of box 1
    r0 = nres; d0 = ndone; fnum = 0;
    pulse_start(3);
    run_frames(5);
    chk("t6 fc pre", 64'(bus.frame_cnt), 1);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t6 busy", 64'(bus.busy), 0);
    chk("t6 fcnt", 64'(bus.frame_cnt), 0);
    run_frames(6);
    chk("t6 nres", 64'(nres - r0), 1);
    chk("t6 done", 64'(ndone - d0), 0);

    // reset mid-frame
    r0 = nres; d0 = ndone; fnum = 0;
    pulse_start(3);
    run_frames(5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7 busy", 64'(bus.busy), 0);
    chk("t7 fcnt", 64'(bus.frame_cnt), 0);
    chk("t7 hl", 64'(bus.hcount_l), 0);
    chk("t7 res_char", 64'(bus.res_char), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frames(6);
    chk("t7 nres", 64'(nres - r0), 1);
    chk("t7 done", 64'(ndone - d0), 0);

    // table was cleared: box 0 now invalid
    r0 = nres; d0 = ndone;
    bus.char_in = 40'h123456789A;
    pulse_start(1);
    repeat (8) @(posedge clk);
    #1;
    chk("t7 clr nres", 64'(nres - r0), 1);
    chk_res("t7 clr", r0, 3'd0, 40'h0);
    chk("t7 clr done", 64'(ndone - d0), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
